// File: rtl/hex_display_pkg.sv
// Shared constants for the multiplexed 8-digit seven-segment display controller.
package hex_display_pkg;

    localparam int unsigned DIGITS  = 8;
    localparam int unsigned NIB_W   = 4;
    localparam int unsigned SEG_W   = 7;
    localparam int unsigned DATA_W  = DIGITS * NIB_W;
    localparam int unsigned IDX_W   = 3;

    localparam logic [SEG_W-1:0]  SEG_BLANK = 7'h7F;
    localparam logic [DIGITS-1:0] AN_OFF    = 8'hFF;

    // Active-low {g,f,e,d,c,b,a} codes, entry [n] is the glyph for nibble n.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [DIGITS-1:0] an_select(input logic [IDX_W-1:0] idx);
        return ~(DIGITS'(1) << idx);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble to active-low seven-segment decoder.
module hex7seg
    import hex_display_pkg::*;
(
    input  logic [NIB_W-1:0] i_nib,
    output logic [SEG_W-1:0] o_seg_c
);

    always_comb begin
        o_seg_c = SEG_TABLE[i_nib];
    end

endmodule

// File: rtl/hex_display_ctrl.sv
// Time-multiplexed 8-digit hex display driver: shadow register, slot timer,
// digit scanner with dead time, and optional leading-zero blanking.
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int unsigned DIV  = 100000,
    parameter int unsigned DEAD = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              load_i,
    input  logic              en_i,
    input  logic              blank_lz_i,
    output logic [DIGITS-1:0] an_o,
    output logic [SEG_W-1:0]  seg_o,
    output logic              dp_o
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DATA_W-1:0] r_shadow;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DIGITS-1:0] r_an;
    logic [SEG_W-1:0]  r_seg;
    logic              r_dp;

    logic [DATA_W-1:0] w_shadow_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [DIGITS-1:0] w_an_nxt;
    logic [SEG_W-1:0]  w_seg_nxt;
    logic [DATA_W-1:0] w_upper;
    logic [NIB_W-1:0]  w_nib;
    logic [SEG_W-1:0]  w_seg_c;
    logic              w_tick;

    // Nibbles at and above the current digit; all-zero means a leading zero.
    assign w_upper = r_shadow >> {r_idx, 2'b00};
    assign w_nib   = w_upper[NIB_W-1:0];
    assign w_tick  = (r_cnt == CNT_W'(DIV - 1));

    hex7seg u_hex7seg (
        .i_nib   (w_nib),
        .o_seg_c (w_seg_c)
    );

    always_comb begin
        w_shadow_nxt = r_shadow;
        w_cnt_nxt    = r_cnt;
        w_idx_nxt    = r_idx;
        w_an_nxt     = AN_OFF;
        w_seg_nxt    = w_seg_c;

        if (load_i) begin
            w_shadow_nxt = data_i;
        end

        if (en_i) begin
            if (w_tick) begin
                w_cnt_nxt = '0;
                w_idx_nxt = r_idx + IDX_W'(1);
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
            if (r_cnt >= CNT_W'(DEAD)) begin
                w_an_nxt = an_select(r_idx);
            end
        end

        if (blank_lz_i && (r_idx != '0) && (w_upper == '0)) begin
            w_seg_nxt = SEG_BLANK;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_shadow <= '0;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_an     <= AN_OFF;
            r_seg    <= SEG_BLANK;
            r_dp     <= 1'b1;
        end else begin
            r_shadow <= w_shadow_nxt;
            r_cnt    <= w_cnt_nxt;
            r_idx    <= w_idx_nxt;
            r_an     <= w_an_nxt;
            r_seg    <= w_seg_nxt;
            r_dp     <= 1'b1;
        end
    end

    assign an_o  = r_an;
    assign seg_o = r_seg;
    assign dp_o  = r_dp;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed self-checking bench for hex_display_ctrl with a short slot (DIV=4, DEAD=1).
module tb_hex_display_ctrl;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] data_i;
    logic        load_i;
    logic        en_i;
    logic        blank_lz_i;
    logic [7:0]  an_o;
    logic [6:0]  seg_o;
    logic        dp_o;

    int n_checks;
    int n_errors;

    hex_display_ctrl #(
        .DIV  (4),
        .DEAD (1)
    ) u_dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .data_i     (data_i),
        .load_i     (load_i),
        .en_i       (en_i),
        .blank_lz_i (blank_lz_i),
        .an_o       (an_o),
        .seg_o      (seg_o),
        .dp_o       (dp_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic load(input logic [31:0] val);
        data_i = val;
        load_i = 1'b1;
        step();
        load_i = 1'b0;
    endtask

    // Bounded wait until digit d is lit; a timeout is reported as a failed check.
    task automatic wait_digit(input int d);
        logic [7:0] want;
        logic       found;
        want  = ~(8'h01 << d);
        found = 1'b0;
        for (int i = 0; i < 80 && !found; i++) begin
            step();
            if (an_o == want) found = 1'b1;
        end
        if (!found) chk("wait_digit_timeout", {24'h0, an_o}, {24'h0, want});
    endtask

    initial begin
        logic [7:0] e_an;
        n_checks   = 0;
        n_errors   = 0;
        rst_i      = 1'b1;
        data_i     = 32'h0;
        load_i     = 1'b0;
        en_i       = 1'b1;
        blank_lz_i = 1'b0;

        // Reset values
        #1 rst_i = 1'b0;
        #1;
        chk("rst_an",  {24'h0, an_o},  32'hFF);
        chk("rst_seg", {25'h0, seg_o}, 32'h7F);
        chk("rst_dp",  {31'h0, dp_o},  32'h1);
        @(negedge clk_i);
        rst_i = 1'b1;

        // Scan order: dead cycle then three lit cycles per digit, wrapping 7 -> 0
        for (int k = 0; k < 36; k++) begin
            step();
            e_an = 8'hFF;
            if ((k % 4) != 0) e_an = ~(8'h01 << ((k / 4) % 8));
            chk($sformatf("scan_an_%0d", k), {24'h0, an_o}, {24'h0, e_an});
        end

        // Hex decode of a loaded value
        do_reset();
        load(32'h0123_89AF);
        wait_digit(0); chk("dec_d0", {25'h0, seg_o}, 32'h0E);
        wait_digit(1); chk("dec_d1", {25'h0, seg_o}, 32'h08);
        wait_digit(2); chk("dec_d2", {25'h0, seg_o}, 32'h10);
        wait_digit(3); chk("dec_d3", {25'h0, seg_o}, 32'h00);
        wait_digit(7); chk("dec_d7", {25'h0, seg_o}, 32'h40);
        chk("dec_dp", {31'h0, dp_o}, 32'h1);

        // Leading-zero blanking
        do_reset();
        blank_lz_i = 1'b1;
        load(32'h0000_00A5);
        wait_digit(0); chk("lz_d0", {25'h0, seg_o}, 32'h12);
        wait_digit(1); chk("lz_d1", {25'h0, seg_o}, 32'h08);
        for (int d = 2; d < 8; d++) begin
            wait_digit(d);
            chk($sformatf("lz_d%0d", d), {25'h0, seg_o}, 32'h7F);
        end
        load(32'h0);
        wait_digit(0); chk("lz0_d0", {25'h0, seg_o}, 32'h40);
        wait_digit(3); chk("lz0_d3", {25'h0, seg_o}, 32'h7F);
        wait_digit(7); chk("lz0_d7", {25'h0, seg_o}, 32'h7F);
        blank_lz_i = 1'b0;

        // Enable dropped mid-slot, then resumed with the remaining count
        do_reset();
        step(); chk("en_pre0", {24'h0, an_o}, 32'hFF);
        step(); chk("en_pre1", {24'h0, an_o}, 32'hFE);
        en_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("en_off_%0d", i), {24'h0, an_o}, 32'hFF);
        end
        en_i = 1'b1;
        step(); chk("en_res0", {24'h0, an_o}, 32'hFE);
        step(); chk("en_res1", {24'h0, an_o}, 32'hFE);
        step(); chk("en_res2", {24'h0, an_o}, 32'hFF);
        step(); chk("en_res3", {24'h0, an_o}, 32'hFD);

        // Asynchronous reset mid-slot
        do_reset();
        load(32'h1111_1111);
        for (int i = 0; i < 5; i++) step();
        chk("ar_pre_an",  {24'h0, an_o},  32'hFD);
        chk("ar_pre_seg", {25'h0, seg_o}, 32'h79);
        #3 rst_i = 1'b0;
        #1;
        chk("ar_an",  {24'h0, an_o},  32'hFF);
        chk("ar_seg", {25'h0, seg_o}, 32'h7F);
        chk("ar_dp",  {31'h0, dp_o},  32'h1);
        @(negedge clk_i);
        rst_i = 1'b1;
        step(); chk("ar_post_dead", {24'h0, an_o}, 32'hFF);
        step(); chk("ar_post_an",   {24'h0, an_o}, 32'hFE);
        chk("ar_post_seg", {25'h0, seg_o}, 32'h40);

        // data_i changes without load_i, then load_i coincident with a tick
        do_reset();
        load(32'h0000_0005);
        data_i = 32'h0000_0077;
        step(); chk("nl_seg0", {25'h0, seg_o}, 32'h12);
        data_i = 32'hFFFF_FFFF;
        step(); chk("nl_seg1", {25'h0, seg_o}, 32'h12);
        load(32'h0000_0077);
        chk("tk_an0",  {24'h0, an_o},  32'hFE);
        chk("tk_seg0", {25'h0, seg_o}, 32'h12);
        data_i = 32'h0;
        step(); chk("tk_dead", {24'h0, an_o}, 32'hFF);
        step(); chk("tk_an1",  {24'h0, an_o}, 32'hFD);
        chk("tk_seg1", {25'h0, seg_o}, 32'h78);
        wait_digit(0); chk("tk_d0", {25'h0, seg_o}, 32'h78);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
